// File: rtl/lamp_fpu_sqrt_ctrl.sv
// Square-root front end: classifies lamp floats, dispatches normals to the core, rounds (RNE) and repacks its result.
// Optional core watchdog: define LAMP_FPU_SQRT_TIMEOUT_EN.
module lamp_fpu_sqrt_ctrl #(
    parameter int unsigned E_DW           = 8,
    parameter int unsigned F_DW           = 7,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid_i,
    output logic                   op_ready_o,
    input  logic [E_DW+F_DW:0]     op_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [E_DW+F_DW:0]     res_o,
    output logic                   invalid_o,
    output logic                   inexact_o,
    output logic                   core_doSqrt_o,
    output logic                   core_signum_o,
    output logic [E_DW-1:0]        core_extExp_o,
    output logic [F_DW:0]          core_extMant_o,
    input  logic                   core_valid_i,
    input  logic                   core_s_i,
    input  logic [E_DW-1:0]        core_e_i,
    input  logic [F_DW+3:0]        core_f_i
);
    localparam int unsigned W = 1 + E_DW + F_DW;
    localparam logic [W-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};
    localparam logic [W-1:0] PINF = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT_CORE, RESULT} state_t;
    state_t state_q, state_d;

    logic [W-1:0]    res_q, res_d;
    logic            inv_q, inv_d, inx_q, inx_d;
    logic [E_DW-1:0] exp_q, exp_d;
    logic [F_DW:0]   mant_q, mant_d;
    logic            tmo_hit;

    logic            op_s;
    logic [E_DW-1:0] op_e;
    logic [F_DW-1:0] op_f;
    assign {op_s, op_e, op_f} = op_i;

    logic            rnd_up, rnd_carry;
    logic [F_DW+1:0] rnd_mant;
    logic [E_DW-1:0] rnd_e;
    logic [F_DW-1:0] rnd_f;

    always_comb begin
        rnd_up    = core_f_i[2] & (core_f_i[1] | core_f_i[0] | core_f_i[3]);
        rnd_mant  = {1'b0, core_f_i[F_DW+3:3]} + {{(F_DW+1){1'b0}}, rnd_up};
        rnd_carry = rnd_mant[F_DW+1];
        rnd_e     = core_e_i + {{(E_DW-1){1'b0}}, rnd_carry};
        rnd_f     = rnd_carry ? '0 : rnd_mant[F_DW-1:0];
    end

`ifdef LAMP_FPU_SQRT_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     tmo_cnt_q <= '0;
        else if (state_q == WAIT_CORE) tmo_cnt_q <= tmo_cnt_q + CW'(1);
        else                          tmo_cnt_q <= '0;
    end

    assign tmo_hit = (state_q == WAIT_CORE) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Specials are resolved at acceptance so their result is ready the next cycle.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        inv_d   = inv_q;
        inx_d   = inx_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        unique case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    state_d = RESULT;
                    inv_d   = 1'b0;
                    inx_d   = 1'b0;
                    if (op_e == '0) begin
                        res_d = {op_s, {(W-1){1'b0}}};
                    end else if (op_e == '1 && op_f != '0) begin
                        res_d = QNAN;
                        inv_d = ~op_f[F_DW-1];
                    end else if (op_s) begin
                        res_d = QNAN;
                        inv_d = 1'b1;
                    end else if (op_e == '1) begin
                        res_d = PINF;
                    end else begin
                        state_d = WAIT_CORE;
                        exp_d   = op_e;
                        mant_d  = {1'b1, op_f};
                    end
                end
            end
            WAIT_CORE: begin
                if (core_valid_i) begin
                    state_d = RESULT;
                    res_d   = {core_s_i, rnd_e, rnd_f};
                    inv_d   = 1'b0;
                    inx_d   = |core_f_i[2:0];
                end else if (tmo_hit) begin
                    state_d = RESULT;
                    res_d   = QNAN;
                    inv_d   = 1'b1;
                    inx_d   = 1'b0;
                end
            end
            RESULT: begin
                if (res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q  <= '0;
            inv_q  <= 1'b0;
            inx_q  <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
        end else begin
            res_q  <= res_d;
            inv_q  <= inv_d;
            inx_q  <= inx_d;
            exp_q  <= exp_d;
            mant_q <= mant_d;
        end
    end

    assign op_ready_o     = (state_q == IDLE);
    assign res_valid_o    = (state_q == RESULT);
    assign core_doSqrt_o  = (state_q == WAIT_CORE);
    assign core_signum_o  = 1'b0;
    assign core_extExp_o  = exp_q;
    assign core_extMant_o = mant_q;
    assign res_o          = res_q;
    assign invalid_o      = inv_q;
    assign inexact_o      = inx_q;
endmodule

// File: tb/tb_lamp_fpu_sqrt_ctrl.sv
// Directed bench for lamp_fpu_sqrt_ctrl: dispatch, specials, rounding, backpressure, reset abort, optional watchdog.
module tb_lamp_fpu_sqrt_ctrl;
    logic        clk_tb = 1'b0;
    logic        rst;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [15:0] op_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [15:0] res_o;
    logic        invalid_o;
    logic        inexact_o;
    logic        core_doSqrt_o;
    logic        core_signum_o;
    logic [7:0]  core_extExp_o;
    logic [7:0]  core_extMant_o;
    logic        core_valid_i;
    logic        core_s_i;
    logic [7:0]  core_e_i;
    logic [10:0] core_f_i;

    int errors = 0;
    int checks = 0;

    lamp_fpu_sqrt_ctrl #(.E_DW(8), .F_DW(7), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk_tb), .rst(rst),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_i(op_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o),
        .invalid_o(invalid_o), .inexact_o(inexact_o),
        .core_doSqrt_o(core_doSqrt_o), .core_signum_o(core_signum_o),
        .core_extExp_o(core_extExp_o), .core_extMant_o(core_extMant_o),
        .core_valid_i(core_valid_i), .core_s_i(core_s_i),
        .core_e_i(core_e_i), .core_f_i(core_f_i)
    );

    always #5 clk_tb = ~clk_tb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic take_result();
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        check("back_to_idle_ready", op_ready_o, 1);
        check("back_to_idle_valid", res_valid_o, 0);
    endtask

    task automatic do_special(input string tag, input logic [15:0] op, input logic [15:0] exp_res,
                              input logic exp_inv);
        op_valid_i = 1'b1;
        op_i       = op;
        step();
        op_valid_i = 1'b0;
        check({tag, "_valid"}, res_valid_o, 1);
        check({tag, "_res"}, res_o, exp_res);
        check({tag, "_inv"}, invalid_o, exp_inv);
        check({tag, "_inx"}, inexact_o, 0);
        check({tag, "_dosqrt"}, core_doSqrt_o, 0);
        take_result();
    endtask

    task automatic do_round(input string tag, input logic [7:0] e, input logic [10:0] f,
                            input logic [15:0] exp_res, input logic exp_inx);
        op_valid_i = 1'b1;
        op_i       = 16'h3F80;
        step();
        op_valid_i = 1'b0;
        check({tag, "_dosqrt"}, core_doSqrt_o, 1);
        core_valid_i = 1'b1;
        core_s_i     = 1'b0;
        core_e_i     = e;
        core_f_i     = f;
        step();
        core_valid_i = 1'b0;
        check({tag, "_valid"}, res_valid_o, 1);
        check({tag, "_res"}, res_o, exp_res);
        check({tag, "_inx"}, inexact_o, exp_inx);
        check({tag, "_inv"}, invalid_o, 0);
        take_result();
    endtask

    initial begin
        rst = 1'b0; op_valid_i = 1'b0; op_i = '0; res_ready_i = 1'b0;
        core_valid_i = 1'b0; core_s_i = 1'b0; core_e_i = '0; core_f_i = '0;
        #1;
        check("rst_op_ready", op_ready_o, 1);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_dosqrt", core_doSqrt_o, 0);
        check("rst_res", res_o, 0);
        check("rst_flags", {invalid_o, inexact_o}, 0);
        step(); step();
        rst = 1'b1;
        step();

        // core_valid_i in IDLE is ignored
        core_valid_i = 1'b1; core_e_i = 8'h81; core_f_i = 11'b1_0100000_000;
        step();
        core_valid_i = 1'b0;
        check("stray_core_valid", res_valid_o, 0);

        // normal dispatch: 25.0 -> 5.0
        op_valid_i = 1'b1; op_i = 16'h41C8;
        step();
        op_valid_i = 1'b0;
        check("disp_dosqrt", core_doSqrt_o, 1);
        check("disp_exp", core_extExp_o, 8'h83);
        check("disp_mant", core_extMant_o, 8'hC8);
        check("disp_signum", core_signum_o, 0);
        check("disp_op_ready", op_ready_o, 0);
        step();
        check("disp_hold_dosqrt", core_doSqrt_o, 1);
        check("disp_hold_exp", core_extExp_o, 8'h83);
        check("disp_no_result", res_valid_o, 0);
        core_valid_i = 1'b1; core_s_i = 1'b0; core_e_i = 8'h81; core_f_i = 11'b1_0100000_000;
        step();
        core_valid_i = 1'b0;
        check("sqrt25_valid", res_valid_o, 1);
        check("sqrt25_res", res_o, 16'h40A0);
        check("sqrt25_inx", inexact_o, 0);
        check("sqrt25_inv", invalid_o, 0);
        check("sqrt25_dosqrt_low", core_doSqrt_o, 0);
        take_result();

        do_special("neg_two", 16'hC000, 16'h7FC0, 1'b1);
        do_special("snan",    16'h7F81, 16'h7FC0, 1'b1);
        do_special("qnan",    16'h7FC1, 16'h7FC0, 1'b0);
        do_special("pinf",    16'h7F80, 16'h7F80, 1'b0);
        do_special("nzero",   16'h8000, 16'h8000, 1'b0);
        do_special("denorm",  16'h0001, 16'h0000, 1'b0);

        do_round("rnd_carry", 8'h80, 11'b1_1111111_100, 16'h4080, 1'b1);
        do_round("rnd_tie",   8'h7F, 11'b1_0000000_100, 16'h3F80, 1'b1);
        do_round("rnd_down",  8'h7F, 11'b1_0000001_001, 16'h3F81, 1'b1);

        // backpressure: result held, new operand not taken
        op_valid_i = 1'b1; op_i = 16'hC000;
        step();
        op_i = 16'h7F80;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", res_valid_o, 1);
            check("bp_res", res_o, 16'h7FC0);
            check("bp_inv", invalid_o, 1);
            check("bp_op_ready", op_ready_o, 0);
            step();
        end
        op_valid_i = 1'b0;
        check("bp_res_last", res_o, 16'h7FC0);
        take_result();
        step();
        check("bp_no_second", res_valid_o, 0);

        // reset while waiting on the core
        op_valid_i = 1'b1; op_i = 16'h41C8;
        step();
        op_valid_i = 1'b0;
        check("abort_dosqrt_pre", core_doSqrt_o, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_dosqrt", core_doSqrt_o, 0);
        check("abort_res_valid", res_valid_o, 0);
        step();
        rst = 1'b1;
        core_valid_i = 1'b1; core_e_i = 8'h81; core_f_i = 11'b1_0100000_000;
        step();
        core_valid_i = 1'b0;
        check("abort_no_result", res_valid_o, 0);
        check("abort_idle", op_ready_o, 1);
        step();
        check("abort_no_result2", res_valid_o, 0);

`ifdef LAMP_FPU_SQRT_TIMEOUT_EN
        op_valid_i = 1'b1; op_i = 16'h41C8;
        step();
        op_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("tmo_wait_dosqrt", core_doSqrt_o, 1);
            check("tmo_wait_valid", res_valid_o, 0);
            step();
        end
        check("tmo_valid", res_valid_o, 1);
        check("tmo_res", res_o, 16'h7FC0);
        check("tmo_inv", invalid_o, 1);
        check("tmo_inx", inexact_o, 0);
        check("tmo_dosqrt", core_doSqrt_o, 0);
        core_valid_i = 1'b1; core_e_i = 8'h81; core_f_i = 11'b1_0100000_000;
        step();
        core_valid_i = 1'b0;
        check("tmo_late_res", res_o, 16'h7FC0);
        take_result();
        step();
        check("tmo_late_ignored", res_valid_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lamp_fpu_sqrt_ctrl.md
Name: lamp_fpu_sqrt_ctrl

Overview:
Front-end controller and result packer around the lampFPU square-root core; it sits directly upstream and downstream of that core. It accepts a packed 16-bit lamp float (1/8/7) on a valid/ready handshake and classifies it. Special operands are resolved locally. Normal positive operands are unpacked and dispatched to the core on the core's doSqrt / signum / extExp / extMant interface. The core's unrounded result is rounded (RNE), repacked and returned on a valid/ready handshake.

Parameters:
E_DW, 8, exponent width (LAMP_FLOAT_E_DW)
F_DW, 7, fraction width (LAMP_FLOAT_F_DW)
TIMEOUT_CYCLES, 64, core watchdog limit; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
op_valid_i  in  1  operand valid
op_ready_o  out  1  operand ready; high only in IDLE
op_i  in  1+E_DW+F_DW  packed operand {s,e,f}
res_valid_o  out  1  result valid
res_ready_i  in  1  result accepted
res_o  out  1+E_DW+F_DW  packed result
invalid_o  out  1  IEEE invalid flag, qualified by res_valid_o
inexact_o  out  1  IEEE inexact flag, qualified by res_valid_o
core_doSqrt_o  out  1  core request
core_signum_o  out  1  operand sign (always 0 when dispatched)
core_extExp_o  out  E_DW  biased exponent
core_extMant_o  out  1+F_DW  {1'b1, frac}
core_valid_i  in  1  core result valid
core_s_i  in  1  core sign
core_e_i  in  E_DW  core biased exponent
core_f_i  in  F_DW+4  {hidden, frac[F_DW-1:0], guard, round, sticky}

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0 except op_ready_o=1. core_doSqrt_o drops immediately.
- FSM states: IDLE, WAIT_CORE, RESULT.
- IDLE:
  - Accept when op_valid_i & op_ready_o.
  - Classify the registered operand.
  - Special operand -> RESULT.
  - Normal positive operand -> WAIT_CORE; latch core_extExp_o and core_extMant_o.
- Classification and special results (all inexact=0):
  - e=0 (zero or denormal, flush-to-zero) -> {s,0...}, i.e. ±0; invalid=0.
  - e=all-ones, f≠0 (NaN) -> canonical qNaN 0x7FC0; invalid=1 iff sNaN (f MSB=0).
  - s=1, nonzero, non-NaN (incl. -inf) -> 0x7FC0; invalid=1.
  - +inf -> 0x7F80; invalid=0.
- WAIT_CORE:
  - core_doSqrt_o held high from the cycle after acceptance through the cycle core_valid_i is sampled high.
  - Deasserted the following cycle, then -> RESULT.
  - Core fields are stable throughout.
- Rounding (RNE):
  - lsb=core_f_i[3], g=[2], r=[1], st=[0].
  - up = g & (r|st|lsb).
  - mant = core_f_i[F_DW+3:3] + up.
  - Carry-out sets frac=0 and e=core_e_i+1.
  - inexact = g|r|st; invalid=0.
  - res_o = {core_s_i, e, frac}.
- RESULT:
  - res_valid_o=1; res_o and flags held stable until res_ready_i=1.
  - Then -> IDLE. op_ready_o rises the next cycle; there is no same-cycle re-accept.
- Latency:
  - Special: accept at cycle N -> res_valid_o at N+1.
  - Normal: core_valid_i at cycle M -> res_valid_o at M+1.
- core_valid_i outside WAIT_CORE is ignored.
- op_valid_i outside IDLE is ignored.
- Reset in any state aborts the operation; no result is produced.

Optional Feature:
LAMP_FPU_SQRT_TIMEOUT_EN
- Defined: a cycle counter runs in WAIT_CORE.
  - If TIMEOUT_CYCLES elapse without core_valid_i: drop core_doSqrt_o, go to RESULT with res_o=0x7FC0, invalid=1, inexact=0.
  - A late core_valid_i is then ignored.
- Undefined: no counter; WAIT_CORE waits indefinitely.

Test Plan:
- Normal dispatch: op_i=0x41C8 (25.0) -> core_extExp_o=0x83, core_extMant_o=0xC8, core_doSqrt_o high from the next cycle. Core returns s=0, e=0x81, f=0b1_0100000_000 -> res_o=0x40A0 (5.0), inexact=0, res_valid_o one cycle after core_valid_i, core_doSqrt_o low after.
- Specials, each with res_valid_o one cycle after accept and core_doSqrt_o never asserted:
  - 0xC000 -> 0x7FC0, invalid=1
  - 0x7F81 -> 0x7FC0, invalid=1
  - 0x7FC1 -> 0x7FC0, invalid=0
  - 0x7F80 -> 0x7F80
  - 0x8000 -> 0x8000
  - 0x0001 -> 0x0000
- Rounding, core outputs:
  - e=0x80, f=0b1_1111111_100 -> 0x4080, inexact=1 (carry).
  - e=0x7F, f=0b1_0000000_100 -> 0x3F80, inexact=1 (tie to even).
  - e=0x7F, f=0b1_0000001_001 -> 0x3F81, inexact=1.
- Backpressure: hold res_ready_i=0 for 3 cycles -> res_o/flags stable, op_ready_o=0, a new op_valid_i is not accepted. Raise res_ready_i -> IDLE, op_ready_o=1 the next cycle.
- Reset mid-operation: assert rst=0 in WAIT_CORE -> core_doSqrt_o=0 and res_valid_o=0 immediately. A subsequent core_valid_i pulse after reset release produces no result.
- With LAMP_FPU_SQRT_TIMEOUT_EN, TIMEOUT_CYCLES=8: core silent -> after 8 cycles res_o=0x7FC0, invalid=1. A core_valid_i arriving later is ignored.
